// File: rtl/gups_pkg.sv
// Shared types for the GUPS scheduler: address/count widths and the run-control states.
package gups_pkg;

    localparam int GUPS_ADDR_W = 64;
    localparam int GUPS_CNT_W  = 32;

    typedef logic [GUPS_ADDR_W-1:0] addr_t;
    typedef logic [GUPS_CNT_W-1:0]  cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/gups_addr_fifo.sv
// In-order FIFO of read addresses awaiting their memory responses.
module gups_addr_fifo
    import gups_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [GUPS_ADDR_W-1:0] push_data,
    input  logic                   pop,
    output logic [GUPS_ADDR_W-1:0] rd_data,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [GUPS_ADDR_W-1:0] mem_q [DEPTH];
    logic [AW:0]            wptr_q;
    logic [AW:0]            rptr_q;
    logic                   do_push;
    logic                   do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= push_data;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gups_sched.sv
// GUPS scheduler: round-robin read issue from generator lanes, then write-back of
// mem[a] ^ a for every returned read, bounded by MAX_OUT outstanding reads.
module gups_sched
    import gups_pkg::*;
#(
    parameter int NUM_GEN = 4,
    parameter int MAX_OUT = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [GUPS_CNT_W-1:0]          num_updates,
    input  logic [GUPS_ADDR_W-1:0]         range_mask,
    input  logic [NUM_GEN-1:0]             gen_valid,
    input  logic [GUPS_ADDR_W*NUM_GEN-1:0] gen_addr,
    output logic [NUM_GEN-1:0]             gen_ready,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic                           mem_req_write,
    output logic [GUPS_ADDR_W-1:0]         mem_req_addr,
    output logic [GUPS_ADDR_W-1:0]         mem_req_wdata,
    input  logic                           mem_rsp_valid,
    output logic                           mem_rsp_ready,
    input  logic [GUPS_ADDR_W-1:0]         mem_rsp_data,
    output logic                           busy,
    output logic                           done,
    output logic [GUPS_CNT_W-1:0]          update_count,
    output logic [1:0]                     dbg_state
);

    localparam int PW = (NUM_GEN > 1) ? $clog2(NUM_GEN) : 1;
    localparam int OW = $clog2(MAX_OUT) + 1;

    sched_state_t           state_q;
    logic                   busy_q;
    logic                   done_q;
    logic [GUPS_CNT_W-1:0]  num_q;
    logic [GUPS_ADDR_W-1:0] mask_q;
    logic [GUPS_CNT_W-1:0]  issued_q;
    logic [GUPS_CNT_W-1:0]  ucnt_q;
    logic [OW-1:0]          out_q;
    logic [PW-1:0]          ptr_q;
    logic                   wr_full_q;
    logic [GUPS_ADDR_W-1:0] wr_addr_q;
    logic [GUPS_ADDR_W-1:0] wr_data_q;

    logic [PW-1:0]          sel;
    logic                   sel_vld;
    logic [GUPS_ADDR_W-1:0] sel_addr;
    logic                   rd_ok;
    logic                   rd_fire;
    logic                   wr_fire;
    logic                   rsp_fire;
    logic                   start_ok;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [GUPS_ADDR_W-1:0] fifo_head;

    // First pass searches lanes at or after the pointer, second pass wraps around.
    always_comb begin
        sel      = '0;
        sel_vld  = 1'b0;
        sel_addr = '0;
        for (int i = 0; i < NUM_GEN; i++) begin
            if (!sel_vld && gen_valid[i] && (i >= int'(ptr_q))) begin
                sel      = PW'(i);
                sel_vld  = 1'b1;
                sel_addr = gen_addr[i*GUPS_ADDR_W +: GUPS_ADDR_W];
            end
        end
        for (int i = 0; i < NUM_GEN; i++) begin
            if (!sel_vld && gen_valid[i]) begin
                sel      = PW'(i);
                sel_vld  = 1'b1;
                sel_addr = gen_addr[i*GUPS_ADDR_W +: GUPS_ADDR_W];
            end
        end
    end

    // Every channel transfers on valid && ready; a pending write owns the request port.
    assign rd_ok = (state_q == RUN) && !wr_full_q && (out_q < OW'(MAX_OUT)) && !fifo_full
                   && (issued_q < num_q) && sel_vld;
    assign rd_fire  = rd_ok && mem_req_ready;
    assign wr_fire  = wr_full_q && mem_req_ready;
    assign start_ok = (state_q == IDLE) && start;

    assign mem_req_valid = wr_full_q || rd_ok;
    assign mem_req_write = wr_full_q;
    assign mem_req_addr  = wr_full_q ? wr_addr_q : (sel_addr & mask_q);
    assign mem_req_wdata = wr_full_q ? wr_data_q : '0;
    assign gen_ready     = rd_fire ? (NUM_GEN'(1) << sel) : '0;
    assign mem_rsp_ready = !wr_full_q || mem_req_ready;
    assign rsp_fire      = mem_rsp_valid && mem_rsp_ready && !fifo_empty;

    assign busy         = busy_q;
    assign done         = done_q;
    assign update_count = ucnt_q;
    assign dbg_state    = state_q;

    gups_addr_fifo #(
        .DEPTH (MAX_OUT)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_fire),
        .push_data (sel_addr & mask_q),
        .pop       (rsp_fire),
        .rd_data   (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (num_updates != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issued_q == num_q) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((out_q == '0) && !wr_full_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q     <= '0;
            mask_q    <= '0;
            issued_q  <= '0;
            ucnt_q    <= '0;
            out_q     <= '0;
            ptr_q     <= '0;
            wr_full_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            if (start_ok) begin
                num_q    <= num_updates;
                mask_q   <= range_mask;
                issued_q <= '0;
                ucnt_q   <= '0;
                out_q    <= '0;
            end else begin
                if (rd_fire) begin
                    issued_q <= issued_q + 1'b1;
                    ptr_q    <= (sel == PW'(NUM_GEN - 1)) ? '0 : sel + 1'b1;
                end
                if (wr_fire) begin
                    ucnt_q <= ucnt_q + 1'b1;
                end
                if (rd_fire && !rsp_fire) begin
                    out_q <= out_q + 1'b1;
                end else if (!rd_fire && rsp_fire) begin
                    out_q <= out_q - 1'b1;
                end
            end
            // A response arriving while the old write drains reloads the register.
            if (rsp_fire) begin
                wr_full_q <= 1'b1;
                wr_addr_q <= fifo_head;
                wr_data_q <= mem_rsp_data ^ fifo_head;
            end else if (wr_fire) begin
                wr_full_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gups_sched.sv
// Directed-plus-random bench for gups_sched against a queue-based behavioural model.
module tb_gups_sched;

    localparam int NG = 4;
    localparam int MO = 8;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [31:0]     num_updates;
    logic [63:0]     range_mask;
    logic [NG-1:0]   gen_valid;
    logic [64*NG-1:0] gen_addr;
    logic [NG-1:0]   gen_ready;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_write;
    logic [63:0]     mem_req_addr;
    logic [63:0]     mem_req_wdata;
    logic            mem_rsp_valid;
    logic            mem_rsp_ready;
    logic [63:0]     mem_rsp_data;
    logic            busy;
    logic            done;
    logic [31:0]     update_count;
    logic [1:0]      dbg_state;

    gups_sched #(.NUM_GEN(NG), .MAX_OUT(MO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .num_updates   (num_updates),
        .range_mask    (range_mask),
        .gen_valid     (gen_valid),
        .gen_addr      (gen_addr),
        .gen_ready     (gen_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_write (mem_req_write),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_data  (mem_rsp_data),
        .busy          (busy),
        .done          (done),
        .update_count  (update_count),
        .dbg_state     (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model state: a run is a count of reads; each read address waits in pend_q until its
    // response, then the expected write {addr, data^addr} waits in exp_q until accepted.
    bit           m_run;
    int           m_num;
    logic [63:0]  m_mask;
    int           m_issued;
    int           m_out;
    int           m_writes;
    int           m_ptr;
    int           n_reads;
    logic [63:0]  pend_q[$];
    logic [127:0] exp_q[$];
    int           grant_log[$];
    logic [63:0]  last_raddr;
    logic [63:0]  last_wdata;

    int           req_pct;
    int           rsp_pct;
    bit           rsp_en;
    bit           rsp_fixed;
    bit           rand_gen;
    bit           cur_rsp_v;
    logic [63:0]  cur_rsp_d;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick();
        for (int k = 0; k < NG; k++) begin
            if (gen_valid[(m_ptr + k) % NG]) return (m_ptr + k) % NG;
        end
        return 0;
    endfunction

    // One clock: drive inputs at the falling edge, check outputs 1ns later, update model.
    task automatic step();
        int           lane;
        int           gl;
        bit           exp_read;
        logic [NG-1:0] exp_gr;
        logic [127:0] wr;
        logic [63:0]  a;
        gl = -1;
        mem_req_ready = ($urandom_range(99) < req_pct);
        if (!cur_rsp_v && rsp_en && pend_q.size() != 0 && $urandom_range(99) < rsp_pct) begin
            cur_rsp_v = 1'b1;
            cur_rsp_d = rsp_fixed ? 64'hA0 : {$urandom, $urandom};
        end
        mem_rsp_valid = cur_rsp_v;
        mem_rsp_data  = cur_rsp_d;
        #1;
        exp_read = m_run && exp_q.size() == 0 && m_out < MO && m_issued < m_num && gen_valid != '0;
        chk("req_valid", mem_req_valid, exp_q.size() != 0 || exp_read);
        chk("rsp_ready", mem_rsp_ready, exp_q.size() == 0 || mem_req_ready);
        lane   = rr_pick();
        exp_gr = '0;
        if (exp_read && mem_req_ready) exp_gr[lane] = 1'b1;
        chk("gen_ready", gen_ready, exp_gr);
        if (exp_q.size() != 0) begin
            chk("req_write_wr", mem_req_write, 1'b1);
            chk("wr_addr", mem_req_addr, exp_q[0][127:64]);
            chk("wr_data", mem_req_wdata, exp_q[0][63:0]);
            if (mem_req_ready) begin
                wr = exp_q.pop_front();
                m_writes++;
                last_wdata = wr[63:0];
            end
        end else if (exp_read) begin
            a = gen_addr[lane*64 +: 64] & m_mask;
            chk("req_write_rd", mem_req_write, 1'b0);
            chk("rd_addr", mem_req_addr, a);
            if (mem_req_ready) begin
                pend_q.push_back(a);
                m_issued++;
                m_out++;
                m_ptr = (lane + 1) % NG;
                grant_log.push_back(lane);
                gl = lane;
                n_reads++;
                last_raddr = a;
            end
        end
        if (cur_rsp_v && mem_rsp_ready === 1'b1) begin
            if (pend_q.size() != 0) begin
                a = pend_q.pop_front();
                exp_q.push_back({a, cur_rsp_d ^ a});
                m_out--;
            end
            cur_rsp_v = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        if (rand_gen) begin
            for (int i = 0; i < NG; i++) begin
                if (i == gl) begin
                    gen_valid[i] = 1'($urandom_range(1));
                    gen_addr[i*64 +: 64] = {$urandom, $urandom};
                end else if (!gen_valid[i] && $urandom_range(1) == 1) begin
                    gen_valid[i] = 1'b1;
                    gen_addr[i*64 +: 64] = {$urandom, $urandom};
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        cur_rsp_v = 1'b0;
        pend_q.delete();
        exp_q.delete();
        m_run = 1'b0;
        m_ptr = 0;
        m_out = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_gen_ready", gen_ready, '0);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_rsp_ready", mem_rsp_ready, 1'b1);
        chk("rst_upd_count", update_count, '0);
        chk("rst_state", dbg_state, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start(input int n, input logic [63:0] mask);
        start = 1'b1;
        num_updates = n;
        range_mask = mask;
        step();
        start = 1'b0;
        num_updates = $urandom;
        range_mask = {$urandom, $urandom};
        m_num = n;
        m_mask = mask;
        m_issued = 0;
        m_writes = 0;
        m_run = (n != 0);
        n_reads = 0;
        grant_log.delete();
        chk("start_busy", busy, n != 0);
        chk("start_done", done, n == 0);
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            step();
            if (done === 1'b1) seen = 1'b1;
        end
        chk("done_seen", seen, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_upd_count", update_count, m_num);
        chk("done_writes", m_writes, m_num);
        m_run = 1'b0;
        step();
        chk("done_pulse", done, 1'b0);
        chk("upd_count_hold", update_count, m_num);
    endtask

    initial begin
        int exp_rr0[5];
        int exp_rr1[4];
        bit found;
        logic [63:0] s_addr;
        logic [63:0] s_data;
        exp_rr0 = '{0, 1, 2, 3, 0};
        exp_rr1 = '{0, 1, 3, 0};
        start = 1'b0;
        num_updates = '0;
        range_mask = '0;
        gen_valid = '0;
        gen_addr = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        req_pct = 100;
        rsp_pct = 100;
        rsp_en = 1'b1;
        rsp_fixed = 1'b0;
        rand_gen = 1'b0;
        cur_rsp_v = 1'b0;
        cur_rsp_d = '0;
        m_num = 0;
        m_mask = '0;
        m_issued = 0;
        m_writes = 0;
        n_reads = 0;
        last_raddr = '0;
        last_wdata = '0;

        // Reset values
        do_reset();

        // Single lane with a narrow mask and fixed read data
        rsp_fixed = 1'b1;
        gen_valid = 4'b0001;
        gen_addr[63:0] = 64'h12345;
        do_start(4, 64'hFFFF);
        wait_done(200);
        chk("t2_raddr", last_raddr, 64'h2345);
        chk("t2_wdata", last_wdata, 64'hA0 ^ 64'h2345);
        rsp_fixed = 1'b0;

        // Round-robin order, all lanes and then with lane 2 idle
        do_reset();
        for (int i = 0; i < NG; i++) gen_addr[i*64 +: 64] = {$urandom, $urandom};
        gen_valid = 4'b1111;
        do_start(5, '1);
        wait_done(300);
        for (int i = 0; i < 5; i++) chk("rr_all", grant_log[i], exp_rr0[i]);
        do_reset();
        gen_valid = 4'b1011;
        do_start(4, '1);
        wait_done(300);
        for (int i = 0; i < 4; i++) chk("rr_skip2", grant_log[i], exp_rr1[i]);

        // Outstanding limit with responses withheld
        rand_gen = 1'b1;
        gen_valid = 4'b1111;
        rsp_en = 1'b0;
        do_start(20, '1);
        repeat (20) step();
        chk("bp_reads", n_reads, MO);
        chk("bp_req_valid", mem_req_valid, 1'b0);
        rsp_en = 1'b1;
        rsp_pct = 50;
        wait_done(3000);

        // Write stalled by the memory port
        rand_gen = 1'b0;
        gen_valid = 4'b0001;
        rsp_pct = 100;
        do_start(3, {$urandom, $urandom});
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (exp_q.size() != 0) found = 1'b1;
        end
        chk("stall_wr_pending", found, 1'b1);
        req_pct = 0;
        step();
        s_addr = mem_req_addr;
        s_data = mem_req_wdata;
        repeat (4) begin
            step();
            chk("stall_write", mem_req_write, 1'b1);
            chk("stall_addr", mem_req_addr, s_addr);
            chk("stall_wdata", mem_req_wdata, s_data);
            chk("stall_rsp_ready", mem_rsp_ready, 1'b0);
            chk("stall_gen_ready", gen_ready, '0);
        end
        req_pct = 100;
        wait_done(300);

        // Zero-length run and a stray response while idle
        do_start(0, '1);
        step();
        chk("zero_done_pulse", done, 1'b0);
        chk("zero_upd_count", update_count, 0);
        cur_rsp_v = 1'b1;
        cur_rsp_d = {$urandom, $urandom};
        step();
        step();
        chk("stray_no_req", mem_req_valid, 1'b0);

        // Reset in the middle of a run, then a clean run
        rand_gen = 1'b1;
        gen_valid = 4'b1111;
        req_pct = 80;
        rsp_pct = 60;
        do_start(30, {$urandom, $urandom});
        repeat (12) step();
        do_reset();
        do_start(6, {$urandom, $urandom});
        wait_done(2000);

        // Randomised runs
        for (int r = 0; r < 3; r++) begin
            req_pct = $urandom_range(100, 30);
            rsp_pct = $urandom_range(100, 20);
            do_start($urandom_range(40, 20), {$urandom, $urandom});
            wait_done(5000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
